// File: rtl/pll_sup_pkg.sv
// Shared types and widths for the PLL lock supervisor.
// Optional status counter is enabled with PLL_LOCK_SUPERVISOR_STATUS_EN.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        ST_ARESET,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN,
        ST_FAIL
    } sup_state_t;

    localparam int RETRY_W = 4;
    localparam int LOSS_W  = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_sup_sync2.sv
// Two-flop synchroniser for the asynchronous PLL lock flag.
module pll_sup_sync2 (
    input  logic i_clk,
    input  logic i_rst,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    // NOTE: sequential state uses non-blocking assignments so both flops sample the old values on the same edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            meta     <= 1'b0;
            sync_out <= 1'b0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, qualifies lock and holds system reset until lock is stable.
// Define PLL_LOCK_SUPERVISOR_STATUS_EN to add the o_loss_cnt lock-loss counter.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int ARESET_CYCLES = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_locked,
    input  logic               i_restart,
    output logic               o_pll_areset,
    output logic               o_rst,
    output logic               o_fail,
    output logic [RETRY_W-1:0] o_retry_cnt
`ifdef PLL_LOCK_SUPERVISOR_STATUS_EN
    ,
    output logic [LOSS_W-1:0]  o_loss_cnt
`endif
);

    localparam int CNT_W = $clog2(max3(ARESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES));
    localparam logic [CNT_W-1:0]   ARESET_LAST  = CNT_W'(ARESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

    sup_state_t         state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [RETRY_W-1:0] retry_nxt;
    logic               lock_s;

    pll_sup_sync2 u_sync (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .async_in (i_locked),
        .sync_out (lock_s)
    );

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_nxt = state;
        retry_nxt = o_retry_cnt;
        case (state)
            ST_ARESET: begin
                if (cnt == ARESET_LAST)
                    state_nxt = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_nxt = ST_STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    if (o_retry_cnt == RETRY_MAX) begin
                        state_nxt = ST_FAIL;
                    end else begin
                        state_nxt = ST_ARESET;
                        retry_nxt = o_retry_cnt + 1'b1;
                    end
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_nxt = ST_WAIT_LOCK;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = ST_RUN;
                    retry_nxt = '0;
                end
            end
            ST_RUN: begin
                if (!lock_s)
                    state_nxt = ST_ARESET;
            end
            ST_FAIL: ;
            default: state_nxt = ST_ARESET;
        endcase

        if (i_restart) begin
            state_nxt = ST_ARESET;
            retry_nxt = '0;
        end

        // Restart re-enters ARESET, so it restarts the pulse like any state change.
        cnt_nxt = cnt;
        if (i_restart || (state_nxt != state))
            cnt_nxt = '0;
        else if (state == ST_ARESET || state == ST_WAIT_LOCK || state == ST_STABLE)
            cnt_nxt = cnt + 1'b1;
    end

    // Outputs are registered from next state so they switch on the same edge as the state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= ST_ARESET;
            cnt          <= '0;
            o_retry_cnt  <= '0;
            o_pll_areset <= 1'b1;
            o_rst        <= 1'b1;
            o_fail       <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            o_retry_cnt  <= retry_nxt;
            o_pll_areset <= (state_nxt == ST_ARESET) || (state_nxt == ST_FAIL);
            o_rst        <= (state_nxt != ST_RUN);
            o_fail       <= (state_nxt == ST_FAIL);
        end
    end

`ifdef PLL_LOCK_SUPERVISOR_STATUS_EN
    logic loss_evt;
    assign loss_evt = (state == ST_RUN) && !lock_s && !i_restart;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            o_loss_cnt <= '0;
        else if (loss_evt && (o_loss_cnt != '1))
            o_loss_cnt <= o_loss_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with small timing parameters.
module tb_pll_lock_supervisor;

    logic       i_clk;
    logic       i_rst;
    logic       i_locked;
    logic       i_restart;
    logic       o_pll_areset;
    logic       o_rst;
    logic       o_fail;
    logic [3:0] o_retry_cnt;
`ifdef PLL_LOCK_SUPERVISOR_STATUS_EN
    logic [7:0] o_loss_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    pll_lock_supervisor #(
        .ARESET_CYCLES (4),
        .LOCK_TIMEOUT  (32),
        .STABLE_CYCLES (8),
        .MAX_RETRIES   (2)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_locked     (i_locked),
        .i_restart    (i_restart),
        .o_pll_areset (o_pll_areset),
        .o_rst        (o_rst),
        .o_fail       (o_fail),
        .o_retry_cnt  (o_retry_cnt)
`ifdef PLL_LOCK_SUPERVISOR_STATUS_EN
        ,
        .o_loss_cnt   (o_loss_cnt)
`endif
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    initial begin
        i_rst     = 1'b1;
        i_locked  = 1'b0;
        i_restart = 1'b0;
        tick(2);
        check("rst_areset", o_pll_areset, 1);
        check("rst_rst", o_rst, 1);
        check("rst_fail", o_fail, 0);
        check("rst_retry", o_retry_cnt, 0);

        // Bring-up: areset for 4 edges, lock at edge 11, o_rst falls at edge 21
        i_rst = 1'b0;
        tick(3);
        check("bring_areset_e3", o_pll_areset, 1);
        tick(1);
        check("bring_areset_e4", o_pll_areset, 0);
        check("bring_rst_e4", o_rst, 1);
        tick(6);
        i_locked = 1'b1;
        tick(10);
        check("bring_rst_e20", o_rst, 1);
        tick(1);
        check("bring_rst_e21", o_rst, 0);
        check("bring_retry", o_retry_cnt, 0);
        check("bring_areset_run", o_pll_areset, 0);

        // Lock loss in RUN for 3 cycles
        i_locked = 1'b0;
        tick(2);
        check("loss_rst_l1", o_rst, 0);
        tick(1);
        check("loss_rst_l2", o_rst, 1);
        check("loss_areset_l2", o_pll_areset, 1);
        i_locked = 1'b1;
        tick(3);
        check("loss_areset_l5", o_pll_areset, 1);
        tick(1);
        check("loss_areset_l6", o_pll_areset, 0);
`ifdef PLL_LOCK_SUPERVISOR_STATUS_EN
        check("loss_cnt", o_loss_cnt, 1);
`endif
        tick(8);
        check("loss_rst_l14", o_rst, 1);
        tick(1);
        check("loss_rst_l15", o_rst, 0);

        // Restart, then a lock dropout at STABLE count 5
        i_restart = 1'b1;
        tick(1);
        i_restart = 1'b0;
        check("rs_rst", o_rst, 1);
        check("rs_areset", o_pll_areset, 1);
        tick(10);
        i_locked = 1'b0;
        tick(2);
        check("drop_rst_r13", o_rst, 1);
        tick(1);
        check("drop_rst_r14", o_rst, 1);
        check("drop_areset_r14", o_pll_areset, 0);
        check("drop_retry", o_retry_cnt, 0);
        i_locked = 1'b1;
        tick(2);
        check("drop_areset_r16", o_pll_areset, 0);
        tick(8);
        check("drop_rst_r24", o_rst, 1);
        tick(1);
        check("drop_rst_r25", o_rst, 0);

        // No lock: two retries, then FAIL
        i_locked  = 1'b0;
        i_restart = 1'b1;
        tick(1);
        i_restart = 1'b0;
        tick(3);
        check("to_areset_s4", o_pll_areset, 1);
        tick(1);
        check("to_areset_s5", o_pll_areset, 0);
        tick(31);
        check("to_areset_s36", o_pll_areset, 0);
        check("to_retry_s36", o_retry_cnt, 0);
        tick(1);
        check("to_areset_s37", o_pll_areset, 1);
        check("to_retry_s37", o_retry_cnt, 1);
        tick(4);
        check("to_areset_s41", o_pll_areset, 0);
        tick(32);
        check("to_retry_s73", o_retry_cnt, 2);
        check("to_areset_s73", o_pll_areset, 1);
        tick(35);
        check("to_fail_s108", o_fail, 0);
        tick(1);
        check("fail_fail", o_fail, 1);
        check("fail_areset", o_pll_areset, 1);
        check("fail_rst", o_rst, 1);
        check("fail_retry", o_retry_cnt, 2);
        tick(5);
        check("fail_hold", o_fail, 1);
        i_restart = 1'b1;
        tick(1);
        i_restart = 1'b0;
        check("fail_exit_fail", o_fail, 0);
        check("fail_exit_areset", o_pll_areset, 1);
        check("fail_exit_retry", o_retry_cnt, 0);

        // Restart coincident with the final timeout
        tick(107);
        check("coin_retry_t108", o_retry_cnt, 2);
        check("coin_fail_t108", o_fail, 0);
        i_restart = 1'b1;
        tick(1);
        i_restart = 1'b0;
        check("coin_fail", o_fail, 0);
        check("coin_areset", o_pll_areset, 1);
        check("coin_retry", o_retry_cnt, 0);
        tick(4);
        check("coin_areset_end", o_pll_areset, 0);
        i_locked = 1'b1;

        // Asynchronous reset while in STABLE
        tick(5);
        check("stb_areset_pre", o_pll_areset, 0);
        #2 i_rst = 1'b1;
        #1;
        check("stb_async_areset", o_pll_areset, 1);
        check("stb_async_rst", o_rst, 1);
        check("stb_async_fail", o_fail, 0);
        check("stb_async_retry", o_retry_cnt, 0);
`ifdef PLL_LOCK_SUPERVISOR_STATUS_EN
        check("stb_async_loss", o_loss_cnt, 0);
`endif
        tick(1);
        i_rst = 1'b0;

        // Asynchronous reset while in RUN
        tick(20);
        check("run_rst_pre", o_rst, 0);
        check("run_areset_pre", o_pll_areset, 0);
        #2 i_rst = 1'b1;
        #1;
        check("run_async_rst", o_rst, 1);
        check("run_async_areset", o_pll_areset, 1);
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 SHALL have parameter ARESET_CYCLES, default 16, meaning PLL areset pulse length in i_clk cycles (>=1).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 4096, meaning cycles allowed in WAIT_LOCK before a retry (>=2).
REQ-003 SHALL have parameter STABLE_CYCLES, default 1024, meaning cycles lock must hold continuously before reset release (>=1).
REQ-004 SHALL have parameter MAX_RETRIES, default 3, meaning timeouts tolerated before FAIL (0..15).
REQ-005 SHALL have port i_clk  in  1  free-running reference clock (PLL input clock); the only clock.
REQ-006 SHALL have port i_rst  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port i_locked  in  1  PLL locked flag, asynchronous to i_clk.
REQ-008 SHALL have port i_restart  in  1  synchronous single-cycle request to rerun the lock sequence.
REQ-009 SHALL have port o_pll_areset  out  1  registered reset to the PLL.
REQ-010 SHALL have port o_rst  out  1  registered active-high system reset, high until lock is qualified.
REQ-011 SHALL have port o_fail  out  1  registered; high in FAIL.
REQ-012 SHALL have port o_retry_cnt  out  4  timeouts since last RUN entry or restart.

Function
REQ-013 SHALL synchronise i_locked through two flops; lock_s is the second flop output, the only lock value used.
REQ-014 SHALL implement FSM states ARESET, WAIT_LOCK, STABLE, RUN, FAIL with one shared cycle counter, cleared on every state change.
REQ-015 ARESET: o_pll_areset=1; after ARESET_CYCLES cycles -> WAIT_LOCK.
REQ-016 WAIT_LOCK: lock_s=1 -> STABLE; else counter reaching LOCK_TIMEOUT-1 -> FAIL if o_retry_cnt==MAX_RETRIES, otherwise o_retry_cnt+1 and -> ARESET.
REQ-017 STABLE: lock_s=0 -> WAIT_LOCK (no areset, o_retry_cnt unchanged); counter reaching STABLE_CYCLES-1 -> RUN and o_retry_cnt cleared.
REQ-018 RUN: lock_s=0 -> ARESET.
REQ-019 FAIL: o_pll_areset=1, o_fail=1; exits only on i_restart or i_rst.
REQ-020 i_restart in any state SHALL force ARESET next edge and clear o_retry_cnt; it takes priority over lock loss, timeout and stable completion in the same cycle.
REQ-021 o_rst SHALL be registered from next-state: 0 exactly when the next state is RUN, so o_rst falls on the edge entering RUN and rises on the edge leaving it.
REQ-022 From the first edge sampling i_locked=1 in WAIT_LOCK, o_rst SHALL fall STABLE_CYCLES+2 edges later if lock holds.
REQ-023 o_pll_areset SHALL be 1 exactly while the state is ARESET or FAIL.
REQ-024 Counter width SHALL be clog2 of the largest of ARESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES; no wrap occurs because every terminal count forces a state change.

Reset
REQ-025 On i_rst: state=ARESET, counter=0, synchroniser flops=0, o_pll_areset=1, o_rst=1, o_fail=0, o_retry_cnt=0, o_loss_cnt=0, all asynchronously; assertion mid-sequence SHALL abort it without glitching o_rst low.

Configuration
REQ-026 Macro PLL_LOCK_SUPERVISOR_STATUS_EN defined: adds port o_loss_cnt  out  8  count of RUN->ARESET transitions caused by lock loss, saturating at 255, cleared only by i_rst.
REQ-027 Macro undefined: o_loss_cnt port and its counter SHALL be absent; all other behaviour identical.

Structure
REQ-028 Package pll_sup_pkg SHALL hold the state enum type and the o_retry_cnt/o_loss_cnt width constants.
REQ-029 Synchroniser SHALL be sub-module pll_sup_sync2 (two flops, async reset to 0); the FSM stays in pll_lock_supervisor.

Verification (ARESET_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=2)
REQ-030 Release i_rst, raise i_locked 10 cycles later -> o_pll_areset high 4 cycles; o_rst falls exactly 10 edges after first sampled lock; o_retry_cnt=0.
REQ-031 i_locked held 0 -> three areset pulses, o_retry_cnt 0->1->2, then FAIL: o_fail=1, o_pll_areset=1, o_rst=1; i_restart -> ARESET, o_fail=0, o_retry_cnt=0.
REQ-032 i_locked drops for 3 cycles at STABLE count 5 -> return to WAIT_LOCK, no areset pulse, counter restarts; o_rst still 1.
REQ-033 In RUN, i_locked low for 3 cycles -> o_rst rises 2 edges after first low sample, 4-cycle areset; o_loss_cnt=1 when macro defined.
REQ-034 i_restart in the same cycle as WAIT_LOCK timeout with o_retry_cnt=2 -> ARESET (not FAIL), o_retry_cnt=0.
REQ-035 i_rst asserted in STABLE and in RUN -> all outputs take reset values immediately, without waiting for a clock edge.
